// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: tracks in-flight destinations over PIPE_DEPTH stages and
// drives forward selects, load-use stall and flush bubbles. Optional counters: HAZ_PERF_CNT_EN.
module pipe_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PIPE_DEPTH     = 3,
    parameter int ALU_STAGE      = 1,
    parameter int LOAD_STAGE     = 2,
    parameter int BRANCH_STAGE   = 2,
    parameter int CNT_WIDTH      = 32,
    localparam int STG_W         = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs,
    input  logic                      i_id_rs_used,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rt,
    input  logic                      i_id_rt_used,
    input  logic                      i_id_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_wr_addr,
    input  logic                      i_id_is_load,
    input  logic                      i_flush,
    output logic                      o_stall,
    output logic                      o_id_issue,
    output logic [STG_W-1:0]          o_fwd_rs_sel,
    output logic [STG_W-1:0]          o_fwd_rt_sel
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      o_perf_stall_cnt,
    output logic [CNT_WIDTH-1:0]      o_perf_flush_cnt
`endif
);

    logic [PIPE_DEPTH:1]       r_vld;
    logic [PIPE_DEPTH:1]       r_wr_en;
    logic [PIPE_DEPTH:1]       r_ld;
    logic [REG_ADDR_WIDTH-1:0] r_addr [1:PIPE_DEPTH];

    logic [STG_W:0]            w_rs;
    logic [STG_W:0]            w_rt;
    logic                      w_haz;

    // Returns {not_yet_available, stage}; scanning oldest to youngest lets the youngest match win.
    function automatic logic [STG_W:0] lookup(input logic [REG_ADDR_WIDTH-1:0] op, input logic used);
        logic [STG_W:0] res;
        res = '0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (used && (op != '0) && r_vld[k] && r_wr_en[k] && (r_addr[k] == op)) begin
                if (k >= (r_ld[k] ? LOAD_STAGE : ALU_STAGE))
                    res = {1'b0, STG_W'(k)};
                else
                    res = {1'b1, {STG_W{1'b0}}};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_rs         = lookup(i_id_rs, i_id_rs_used);
        w_rt         = lookup(i_id_rt, i_id_rt_used);
        w_haz        = i_id_valid & (w_rs[STG_W] | w_rt[STG_W]);
        o_stall      = w_haz & ~i_flush;
        o_id_issue   = i_id_valid & ~w_haz & ~i_flush;
        o_fwd_rs_sel = i_id_valid ? w_rs[STG_W-1:0] : '0;
        o_fwd_rt_sel = i_id_valid ? w_rt[STG_W-1:0] : '0;
    end

    // Control bits: stages younger than the branch stage are squashed while they advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld   <= '0;
            r_wr_en <= '0;
        end else begin
            r_vld[1]   <= o_id_issue;
            r_wr_en[1] <= o_id_issue & i_id_wr_en;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_vld[k+1]   <= (i_flush && (k < BRANCH_STAGE)) ? 1'b0 : r_vld[k];
                r_wr_en[k+1] <= (i_flush && (k < BRANCH_STAGE)) ? 1'b0 : r_wr_en[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_addr[1] <= i_id_wr_addr;
        r_ld[1]   <= i_id_is_load;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            r_addr[k+1] <= r_addr[k];
            r_ld[k+1]   <= r_ld[k];
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            if (i_flush && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_perf_stall_cnt = r_stall_cnt;
    assign o_perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: directed decode vectors with hand-computed
// expected outputs queued per cycle and checked by a negedge monitor.
module tb_pipe_hazard_unit;
    localparam int RW    = 5;
    localparam int STG_W = 2;
    localparam int CW    = 32;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic [RW-1:0]   id_rs;
    logic            id_rs_used;
    logic [RW-1:0]   id_rt;
    logic            id_rt_used;
    logic            id_wr_en;
    logic [RW-1:0]   id_wr_addr;
    logic            id_is_load;
    logic            flush;
    logic            stall;
    logic            id_issue;
    logic [STG_W-1:0] fwd_rs_sel;
    logic [STG_W-1:0] fwd_rt_sel;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0]   perf_stall_cnt;
    logic [CW-1:0]   perf_flush_cnt;
`endif

    pipe_hazard_unit dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_valid     (id_valid),
        .i_id_rs        (id_rs),
        .i_id_rs_used   (id_rs_used),
        .i_id_rt        (id_rt),
        .i_id_rt_used   (id_rt_used),
        .i_id_wr_en     (id_wr_en),
        .i_id_wr_addr   (id_wr_addr),
        .i_id_is_load   (id_is_load),
        .i_flush        (flush),
        .o_stall        (stall),
        .o_id_issue     (id_issue),
        .o_fwd_rs_sel   (fwd_rs_sel),
        .o_fwd_rt_sel   (fwd_rt_sel)
`ifdef HAZ_PERF_CNT_EN
        ,
        .o_perf_stall_cnt (perf_stall_cnt),
        .o_perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        string            name;
        logic             stall;
        logic             issue;
        logic [STG_W-1:0] rs;
        logic [STG_W-1:0] rt;
        int               scnt;
        int               fcnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_scnt = 0;
    int   m_fcnt = 0;
    logic cur_stall = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(input logic v, input logic [RW-1:0] rs, input logic rsu,
                       input logic [RW-1:0] rt, input logic rtu, input logic we,
                       input logic [RW-1:0] wa, input logic ld, input logic fl);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_wr_en   = we;
        id_wr_addr = wa;
        id_is_load = ld;
        flush      = fl;
    endtask

    task automatic push(input string n, input logic st, input logic is, input int rss, input int rts);
        exp_t e;
        e.name    = n;
        e.stall   = st;
        e.issue   = is;
        e.rs      = STG_W'(rss);
        e.rt      = STG_W'(rts);
        e.scnt    = m_scnt;
        e.fcnt    = m_fcnt;
        cur_stall = st;
        q.push_back(e);
    endtask

    // Advance one cycle; the counter model follows the events held during that cycle.
    task automatic tick();
        if (rst_n) begin
            if (cur_stall) m_scnt++;
            if (flush)     m_fcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({stall, id_issue, fwd_rs_sel, fwd_rt_sel} !== {e.stall, e.issue, e.rs, e.rt}) begin
                errors++;
                $display("FAIL %s: got stall=%0b issue=%0b rs_sel=%0d rt_sel=%0d, want stall=%0b issue=%0b rs_sel=%0d rt_sel=%0d",
                         e.name, stall, id_issue, fwd_rs_sel, fwd_rt_sel, e.stall, e.issue, e.rs, e.rt);
            end
`ifdef HAZ_PERF_CNT_EN
            checks++;
            if (perf_stall_cnt !== CW'(e.scnt) || perf_flush_cnt !== CW'(e.fcnt)) begin
                errors++;
                $display("FAIL %s_cnt: got stall_cnt=%0d flush_cnt=%0d, want stall_cnt=%0d flush_cnt=%0d",
                         e.name, perf_stall_cnt, perf_flush_cnt, e.scnt, e.fcnt);
            end
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        push("reset_state", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ALU result forwarded from each stage in turn
        drv(1, 0, 0, 0, 0, 1, 3, 0, 0); push("add_r3_issue", 0, 1, 0, 0); tick();
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0); push("fwd_alu_s1",   0, 1, 1, 0); tick();
        push("fwd_alu_s2", 0, 1, 2, 0); tick();
        push("fwd_wb_s3",  0, 1, 3, 0); tick();
        push("r3_retired", 0, 1, 0, 0); tick();

        // load-use: one stall, then forward from stage 2
        drv(1, 0, 0, 0, 0, 1, 5, 1, 0); push("lw_r5_issue",    0, 1, 0, 0); tick();
        drv(1, 0, 0, 5, 1, 0, 0, 0, 0); push("load_use_stall", 1, 0, 0, 0); tick();
        push("load_fwd_s2", 0, 1, 0, 2); tick();

        // youngest writer wins over an older load to the same register
        drv(1, 0, 0, 0, 0, 1, 4, 1, 0); push("lw_r4_issue",   0, 1, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 1, 4, 0, 0); push("add_r4_issue",  0, 1, 0, 0); tick();
        drv(1, 4, 1, 4, 1, 0, 0, 0, 0); push("youngest_wins", 0, 1, 1, 1); tick();
        drv(0, 4, 1, 4, 1, 0, 0, 0, 0); push("id_invalid",    0, 0, 0, 0); tick();

        // r0 is never a hazard
        drv(1, 0, 0, 0, 0, 1, 0, 0, 0); push("add_r0_issue",    0, 1, 0, 0); tick();
        drv(1, 0, 1, 0, 1, 0, 0, 0, 0); push("r0_never_hazard", 0, 1, 0, 0); tick();

        // flush kills decode and stage 1; stage 2 (branch stage) advances intact
        drv(1, 0, 0, 0, 0, 1, 9, 0, 0); push("add_r9_issue",       0, 1, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 1, 8, 0, 0); push("add_r8_issue",       0, 1, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 1, 7, 0, 1); push("flush_blocks_issue", 0, 0, 0, 0); tick();
        drv(1, 7, 1, 9, 1, 0, 0, 0, 0); push("after_flush",        0, 1, 0, 3); tick();
        drv(1, 8, 1, 9, 1, 0, 0, 0, 0); push("flushed_r8_gone",    0, 1, 0, 0); tick();

        // flush overrides a load-use stall
        drv(1, 0, 0, 0, 0, 1, 10, 1, 0); push("lw_r10_issue",     0, 1, 0, 0); tick();
        drv(1, 10, 1, 0, 0, 0, 0, 0, 1); push("flush_over_stall", 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);  push("perf_counts",      0, 0, 0, 0); tick();

        // asynchronous reset with live hazards in the pipe
        drv(1, 0, 0, 0, 0, 1, 12, 0, 0); push("add_r12_issue", 0, 1, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 1, 13, 0, 0); push("add_r13_issue", 0, 1, 0, 0); tick();
        drv(1, 13, 1, 12, 1, 0, 0, 0, 0); push("pre_reset",    0, 1, 1, 2); tick();
        rst_n  = 1'b0;
        m_scnt = 0;
        m_fcnt = 0;
        push("reset_async", 0, 1, 0, 0); tick();
        rst_n = 1'b1;
        drv(1, 12, 1, 13, 1, 0, 0, 0, 0); push("post_reset", 0, 1, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
